// File: rtl/dma_stream_loader_if.sv
// Bundle of the command, stream and DMA write-port signals around dma_stream_loader.
// The master modport is the loader's view; the slave modport is the host/memory side.
interface dma_stream_loader_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_target;
  logic [14:0]  cmd_base;
  logic [15:0]  cmd_len;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         dma_write_en;
  logic [1:0]   dma_target;
  logic [14:0]  dma_addr;
  logic [255:0] dma_wdata;
  logic         busy;
  logic         done;

  modport master (
    input  cmd_valid, cmd_target, cmd_base, cmd_len, s_valid, s_data,
    output cmd_ready, s_ready, dma_write_en, dma_target, dma_addr, dma_wdata, busy, done
  );

  modport slave (
    output cmd_valid, cmd_target, cmd_base, cmd_len, s_valid, s_data,
    input  cmd_ready, s_ready, dma_write_en, dma_target, dma_addr, dma_wdata, busy, done
  );
endinterface

// File: rtl/dma_stream_loader.sv
// Streaming DMA initiator: packs 8 x 32-bit stream words into 256-bit lines and
// issues one single-cycle write per line at base + line index (15-bit wrap).
module dma_stream_loader (
  input  logic                clk,
  input  logic                reset,
  dma_stream_loader_if.master bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [2:0]   idx;
  logic [15:0]  line_cnt;
  logic [15:0]  len;
  logic [14:0]  base;
  logic [1:0]   target;
  logic [223:0] pack;
  logic [14:0]  addr;
  logic [255:0] wdata;
  logic         accept;
  logic         word_take;
  logic         line_full;
  logic [15:0]  line_cnt_inc;

  assign accept       = (state == IDLE) && bus.cmd_valid;
  assign word_take    = (state == RECV) && bus.s_valid;
  assign line_full    = (idx == 3'd7);
  assign line_cnt_inc = line_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) state_next = (bus.cmd_len == 16'd0) ? DONE : RECV;
      end
      RECV: begin
        if (bus.s_valid && line_full) state_next = WRITE;
      end
      WRITE: begin
        state_next = (line_cnt_inc == len) ? DONE : RECV;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready    = 1'b0;
    bus.s_ready      = 1'b0;
    bus.dma_write_en = 1'b0;
    bus.busy         = 1'b1;
    bus.done         = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      RECV:  bus.s_ready      = 1'b1;
      WRITE: bus.dma_write_en = 1'b1;
      DONE:  bus.done         = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

  assign bus.dma_target = target;
  assign bus.dma_addr   = addr;
  assign bus.dma_wdata  = wdata;

  // addr/wdata load on the 8th word so they are stable for the whole WRITE cycle
  // and hold afterwards; lanes 0..6 collect in a separate buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= 3'd0;
      line_cnt <= 16'd0;
      len      <= 16'd0;
      base     <= 15'd0;
      target   <= 2'd0;
      pack     <= '0;
      addr     <= 15'd0;
      wdata    <= '0;
    end else begin
      if (accept) begin
        target   <= bus.cmd_target;
        base     <= bus.cmd_base;
        len      <= bus.cmd_len;
        idx      <= 3'd0;
        line_cnt <= 16'd0;
      end
      if (word_take) begin
        idx <= idx + 3'd1;
        if (line_full) begin
          addr  <= base + line_cnt[14:0];
          wdata <= {bus.s_data, pack};
        end else begin
          for (int i = 0; i < 7; i++) begin
            if (idx == 3'(i)) pack[32*i +: 32] <= bus.s_data;
          end
        end
      end
      if (state == WRITE) line_cnt <= line_cnt_inc;
    end
  end
endmodule

// File: tb/tb_dma_stream_loader.sv
// Directed bench for dma_stream_loader: a transaction-level model predicts every
// line write, the done pulse cycle and busy/target, checked each cycle on negedge.
module tb_dma_stream_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dma_stream_loader_if bus();

  dma_stream_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [1:0]   tgt;
    logic [14:0]  addr;
    logic [255:0] data;
  } wr_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  wr_t          exp_q[$];
  logic [1:0]   model_target = 2'd0;
  bit           active = 1'b0;
  int           writes_left = 0;
  int           exp_done_cyc = -1;
  int           accept_edge = 0;
  int           write_count = 0;
  logic [14:0]  seen_addr[$];
  logic [255:0] last_wdata = '0;
  int           last_write_cyc = -10;
  int           done_seen_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      check("busy", bus.busy, active);
      check("cmd_ready", bus.cmd_ready, !active);
      check("dma_target", bus.dma_target, model_target);
      check("done", bus.done, (cyc == exp_done_cyc));
      if (!active || bus.done) check("s_ready_idle", bus.s_ready, 1'b0);
      if (bus.dma_write_en) begin
        wr_t e;
        write_count++;
        seen_addr.push_back(bus.dma_addr);
        last_wdata = bus.dma_wdata;
        last_write_cyc = cyc;
        check("s_ready_in_write", bus.s_ready, 1'b0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.dma_addr, e.addr);
          check("wr_target", bus.dma_target, e.tgt);
          check("wr_data", bus.dma_wdata, e.data);
          writes_left--;
          if (writes_left == 0) exp_done_cyc = cyc + 1;
        end
      end
      if (bus.done) begin
        done_seen_cyc = cyc;
        if (cyc == exp_done_cyc) active = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.s_valid = 1'b0;
    @(posedge clk);
    active = 1'b0;
    exp_q.delete();
    model_target = 2'd0;
    writes_left = 0;
    exp_done_cyc = -1;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_s_ready", bus.s_ready, 1'b0);
    check("rst_write_en", bus.dma_write_en, 1'b0);
    check("rst_target", bus.dma_target, 2'd0);
    check("rst_addr", bus.dma_addr, 15'd0);
    check("rst_wdata", bus.dma_wdata, 256'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    reset = 1'b0;
  endtask

  task automatic issue_cmd(input logic [1:0] t, input logic [14:0] b, input logic [15:0] l);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_target = t;
    bus.cmd_base = b;
    bus.cmd_len = l;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      fail_now("cmd_accept_timeout");
      bus.cmd_valid = 1'b0;
      return;
    end
    accept_edge = cyc + 1;
    @(posedge clk);
    model_target = t;
    active = 1'b1;
    writes_left = l;
    exp_done_cyc = (l == 16'd0) ? accept_edge : -1;
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n = 0;
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data = w;
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      fail_now("s_ready_timeout");
      bus.s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
  endtask

  task automatic busy_pulse(input logic [1:0] t);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_target = t;
    bus.cmd_base = 15'h1234;
    bus.cmd_len = 16'd5;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (active && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (active) fail_now("done_timeout");
    @(negedge clk);
  endtask

  // builds expected lines, issues the command, streams 8*len words
  task automatic run_cmd(input logic [1:0] t, input logic [14:0] b, input logic [15:0] l,
                         input logic [31:0] seed, input int gapmax, input bit pulse);
    logic [31:0] words[$];
    for (int ln = 0; ln < int'(l); ln++) begin
      wr_t e;
      e.tgt = t;
      e.addr = b + 15'(ln);
      e.data = '0;
      for (int i = 0; i < 8; i++) begin
        logic [31:0] w;
        w = seed + 32'(ln * 8 + i);
        words.push_back(w);
        e.data[32*i +: 32] = w;
      end
      exp_q.push_back(e);
    end
    issue_cmd(t, b, l);
    for (int i = 0; i < words.size(); i++) begin
      if (pulse && i == 3) busy_pulse(~t);
      send_word(words[i], int'($urandom_range(0, gapmax)));
    end
    wait_done();
  endtask

  initial begin
    int wc0;
    bus.cmd_valid = 1'b0;
    bus.cmd_target = 2'd0;
    bus.cmd_base = 15'd0;
    bus.cmd_len = 16'd0;
    bus.s_valid = 1'b0;
    bus.s_data = 32'd0;
    do_reset();

    // single line, back-to-back words 1..8
    wc0 = write_count;
    run_cmd(2'd0, 15'h0010, 16'd1, 32'd1, 0, 1'b0);
    check("t1_write_count", write_count - wc0, 1);
    check("t1_addr", seen_addr[$], 15'h0010);
    check("t1_lane0", last_wdata[31:0], 32'd1);
    check("t1_lane7", last_wdata[255:224], 32'd8);
    check("t1_done_cyc", done_seen_cyc, last_write_cyc + 1);

    // three lines with random stream gaps
    wc0 = write_count;
    run_cmd(2'd2, 15'h0100, 16'd3, 32'h1000_0000, 3, 1'b0);
    check("t2_write_count", write_count - wc0, 3);
    check("t2_addr0", seen_addr[seen_addr.size()-3], 15'h0100);
    check("t2_addr2", seen_addr[$], 15'h0102);
    check("t2_lane7_last", last_wdata[255:224], 32'h1000_0017);

    // zero length
    wc0 = write_count;
    run_cmd(2'd1, 15'h0200, 16'd0, 32'd0, 0, 1'b0);
    check("t3_write_count", write_count - wc0, 0);
    check("t3_done_cyc", done_seen_cyc, accept_edge);

    // address wrap
    wc0 = write_count;
    run_cmd(2'd3, 15'h7FFF, 16'd2, 32'hC000_0000, 1, 1'b0);
    check("t4_write_count", write_count - wc0, 2);
    check("t4_addr0", seen_addr[seen_addr.size()-2], 15'h7FFF);
    check("t4_addr1", seen_addr[$], 15'h0000);

    // reset after 5 words of line 0, then a fresh single line
    wc0 = write_count;
    issue_cmd(2'd1, 15'h0020, 16'd1);
    for (int i = 0; i < 5; i++) send_word(32'hDEAD_0000 + 32'(i), 0);
    do_reset();
    check("t5_no_write", write_count - wc0, 0);
    run_cmd(2'd1, 15'h0030, 16'd1, 32'hA0, 0, 1'b0);
    check("t5_addr", seen_addr[$], 15'h0030);
    check("t5_lane0", last_wdata[31:0], 32'hA0);
    check("t5_lane7", last_wdata[255:224], 32'hA7);

    // command pulsed while busy must be ignored
    wc0 = write_count;
    run_cmd(2'd2, 15'h0400, 16'd2, 32'h5000, 1, 1'b1);
    check("t6_write_count", write_count - wc0, 2);
    check("t6_addr1", seen_addr[$], 15'h0401);
    check("t6_idle_after", bus.cmd_ready, 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end
endmodule
